// File: rtl/pc_seq.sv
// Next-PC sequencer for the fetch stage.
// Drives the PC register's control inputs (write enable/data, branch
// select/value), arbitrates absolute writes, relative branches and fetch
// stalls, and kills a fixed number of advancing fetch slots after every
// redirect. A saturating redirect counter is exposed for debug.
//
// Handshake: imem_ready is a ready qualifier from instruction memory; a fetch
// slot advances only in a cycle where stall=0 and imem_ready=1. br_valid and
// pcw_valid are single-cycle request strobes that are consumed in the cycle
// they are seen (no back-pressure); pcw_valid wins over br_valid.
module pc_seq #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int          FLUSH_DEPTH = 2,
    parameter int          CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc_cur,
    input  logic          stall,
    input  logic          imem_ready,
    input  logic          br_valid,
    input  logic [31:0]   br_off,
    input  logic          pcw_valid,
    input  logic [31:0]   pcw_data,
    output logic          pc_we,
    output logic [31:0]   pc_wd,
    output logic          pc_ib,
    output logic [31:0]   pc_bv,
    output logic          fetch_valid,
    output logic          flush,
    output logic [1:0]    state_o,
    output logic [CW-1:0] redir_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] DEPTH = 4'(FLUSH_DEPTH);

    state_t        r_state;
    logic [3:0]    r_dcnt;
    logic [CW-1:0] r_redir_count;

    state_t        w_next_state;
    logic [3:0]    w_next_dcnt;
    logic          w_redir;
    logic          w_hold;
    logic          w_sat;

    assign w_hold      = stall | ~imem_ready;
    assign w_sat       = &r_redir_count;
    assign state_o     = r_state;
    assign redir_count = r_redir_count;

    // Next-state and PC-control decode; redirects take effect combinationally.
    always_comb begin
        pc_we        = 1'b0;
        pc_wd        = 32'h0;
        pc_ib        = 1'b0;
        pc_bv        = 32'h0;
        fetch_valid  = 1'b0;
        flush        = 1'b0;
        w_next_state = r_state;
        w_next_dcnt  = r_dcnt;
        w_redir      = 1'b0;

        if (rst) begin
            // While reset is held the PC is pinned to the reset vector.
            pc_we        = 1'b1;
            pc_wd        = RESET_VEC;
            flush        = 1'b1;
            w_next_state = BOOT;
            w_next_dcnt  = 4'd0;
        end else if (r_state == BOOT) begin
            pc_we        = 1'b1;
            pc_wd        = RESET_VEC;
            flush        = 1'b1;
            w_next_state = DRAIN;
            w_next_dcnt  = DEPTH;
        end else if (pcw_valid) begin
            pc_we        = 1'b1;
            pc_wd        = pcw_data;
            flush        = 1'b1;
            w_next_state = DRAIN;
            w_next_dcnt  = DEPTH;
            w_redir      = 1'b1;
        end else if (br_valid) begin
            pc_ib        = 1'b1;
            pc_bv        = br_off;
            flush        = 1'b1;
            w_next_state = DRAIN;
            w_next_dcnt  = DEPTH;
            w_redir      = 1'b1;
        end else if (r_state == DRAIN) begin
            flush = 1'b1;
            if (w_hold) begin
                // Slot does not advance, so it does not count toward the drain.
                pc_we = 1'b1;
                pc_wd = pc_cur;
            end else begin
                w_next_dcnt = r_dcnt - 4'd1;
                if (r_dcnt <= 4'd1) begin
                    w_next_state = RUN;
                    w_next_dcnt  = 4'd0;
                end
            end
        end else begin
            // RUN and HOLD share the same decode; only the state differs.
            if (w_hold) begin
                pc_we        = 1'b1;
                pc_wd        = pc_cur;
                w_next_state = HOLD;
            end else begin
                fetch_valid  = 1'b1;
                w_next_state = RUN;
            end
        end
    end

    // State, drain counter and saturating redirect counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BOOT;
            r_dcnt        <= 4'd0;
            r_redir_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_dcnt  <= w_next_dcnt;
            if (w_redir && !w_sat) begin
                r_redir_count <= r_redir_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: each vector drives one cycle of inputs and
// pushes the hand-computed outputs for that cycle; a monitor on the falling
// edge pops and compares against the DUT.
module tb_pc_seq;

    localparam int CW = 4;
    localparam int EW = 1 + 32 + 1 + 32 + 1 + 1 + 2 + CW;

    logic          clk;
    logic          rst;
    logic [31:0]   pc_cur;
    logic          stall;
    logic          imem_ready;
    logic          br_valid;
    logic [31:0]   br_off;
    logic          pcw_valid;
    logic [31:0]   pcw_data;
    logic          pc_we;
    logic [31:0]   pc_wd;
    logic          pc_ib;
    logic [31:0]   pc_bv;
    logic          fetch_valid;
    logic          flush;
    logic [1:0]    state_o;
    logic [CW-1:0] redir_count;

    logic [EW-1:0] exp_q[$];
    int            n_cmp;
    int            n_err;

    pc_seq #(
        .RESET_VEC  (32'h0000_0000),
        .FLUSH_DEPTH(2),
        .CW         (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_cur     (pc_cur),
        .stall      (stall),
        .imem_ready (imem_ready),
        .br_valid   (br_valid),
        .br_off     (br_off),
        .pcw_valid  (pcw_valid),
        .pcw_data   (pcw_data),
        .pc_we      (pc_we),
        .pc_wd      (pc_wd),
        .pc_ib      (pc_ib),
        .pc_bv      (pc_bv),
        .fetch_valid(fetch_valid),
        .flush      (flush),
        .state_o    (state_o),
        .redir_count(redir_count)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and queue the outputs expected for it.
    task automatic vec(
        input logic          i_rst,
        input logic          i_stall,
        input logic          i_rdy,
        input logic          i_bv,
        input logic [31:0]   i_off,
        input logic          i_pv,
        input logic [31:0]   i_pd,
        input logic          e_we,
        input logic [31:0]   e_wd,
        input logic          e_ib,
        input logic [31:0]   e_bv,
        input logic          e_fv,
        input logic          e_fl,
        input logic [1:0]    e_st,
        input logic [CW-1:0] e_rc
    );
        @(posedge clk);
        #1;
        rst        = i_rst;
        stall      = i_stall;
        imem_ready = i_rdy;
        br_valid   = i_bv;
        br_off     = i_off;
        pcw_valid  = i_pv;
        pcw_data   = i_pd;
        exp_q.push_back({e_we, e_wd, e_ib, e_bv, e_fv, e_fl, e_st, e_rc});
    endtask

    // Shorthand for an idle, advancing cycle.
    task automatic adv(input logic e_fv, input logic e_fl, input logic [1:0] e_st,
                       input logic [CW-1:0] e_rc);
        vec(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, e_fv, e_fl, e_st, e_rc);
    endtask

    // Monitor: compare DUT outputs with the oldest queued expectation.
    always @(negedge clk) begin
        logic [EW-1:0] exp_v;
        logic [EW-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {pc_we, pc_wd, pc_ib, pc_bv, fetch_valid, flush, state_o, redir_count};
            n_cmp = n_cmp + 1;
            if (act_v !== exp_v) begin
                n_err = n_err + 1;
                $display("FAIL cycle_outputs #%0d: got we=%b wd=%h ib=%b bv=%h fv=%b fl=%b st=%0d rc=%0d expected we=%b wd=%h ib=%b bv=%h fv=%b fl=%b st=%0d rc=%0d",
                         n_cmp, pc_we, pc_wd, pc_ib, pc_bv, fetch_valid, flush, state_o, redir_count,
                         exp_v[EW-1], exp_v[EW-2 -: 32], exp_v[EW-34], exp_v[EW-35 -: 32],
                         exp_v[CW+3], exp_v[CW+2], exp_v[CW+1 -: 2], exp_v[CW-1:0]);
            end
        end
    end

    // Directed stimulus.
    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        pc_cur     = 32'h40;
        stall      = 1'b0;
        imem_ready = 1'b1;
        br_valid   = 1'b0;
        br_off     = 32'h0;
        pcw_valid  = 1'b0;
        pcw_data   = 32'h0;

        // Boot: reset held for three cycles.
        for (int i = 0; i < 3; i++)
            vec(1, 0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 0, 1, 2'd0, 4'd0);
        // First cycle out of reset is still BOOT, then two drain slots.
        vec(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 0, 1, 2'd0, 4'd0);
        adv(0, 1, 2'd3, 4'd0);
        adv(0, 1, 2'd3, 4'd0);
        adv(1, 0, 2'd1, 4'd0);

        // Backward branch in RUN.
        vec(0, 0, 1, 1, 32'hFFFF_FFF8, 0, 32'h0, 0, 32'h0, 1, 32'hFFFF_FFF8, 0, 1, 2'd1, 4'd0);
        adv(0, 1, 2'd3, 4'd1);
        adv(0, 1, 2'd3, 4'd1);
        adv(1, 0, 2'd1, 4'd1);

        // Simultaneous absolute write, branch and stall: absolute write wins.
        vec(0, 1, 1, 1, 32'h8, 1, 32'h100, 1, 32'h100, 0, 32'h0, 0, 1, 2'd1, 4'd1);
        adv(0, 1, 2'd3, 4'd2);
        adv(0, 1, 2'd3, 4'd2);
        adv(1, 0, 2'd1, 4'd2);

        // Stall in RUN for three cycles, then release.
        vec(0, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'h40, 0, 32'h0, 0, 0, 2'd1, 4'd2);
        vec(0, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'h40, 0, 32'h0, 0, 0, 2'd2, 4'd2);
        vec(0, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'h40, 0, 32'h0, 0, 0, 2'd2, 4'd2);
        adv(1, 0, 2'd2, 4'd2);
        adv(1, 0, 2'd1, 4'd2);

        // Instruction memory not ready behaves like a stall.
        vec(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h40, 0, 32'h0, 0, 0, 2'd1, 4'd2);
        adv(1, 0, 2'd2, 4'd2);

        // Branch, stall four cycles inside DRAIN, then a second branch mid-DRAIN.
        vec(0, 0, 1, 1, 32'h10, 0, 32'h0, 0, 32'h0, 1, 32'h10, 0, 1, 2'd1, 4'd2);
        for (int i = 0; i < 4; i++)
            vec(0, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'h40, 0, 32'h0, 0, 1, 2'd3, 4'd3);
        adv(0, 1, 2'd3, 4'd3);
        vec(0, 0, 1, 1, 32'h20, 0, 32'h0, 0, 32'h0, 1, 32'h20, 0, 1, 2'd3, 4'd3);
        adv(0, 1, 2'd3, 4'd4);
        adv(0, 1, 2'd3, 4'd4);
        adv(1, 0, 2'd1, 4'd4);

        // Absolute write from HOLD while still stalled.
        vec(0, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'h40, 0, 32'h0, 0, 0, 2'd1, 4'd4);
        vec(0, 1, 1, 0, 32'h0, 1, 32'h200, 1, 32'h200, 0, 32'h0, 0, 1, 2'd2, 4'd4);
        adv(0, 1, 2'd3, 4'd5);
        adv(0, 1, 2'd3, 4'd5);
        adv(1, 0, 2'd1, 4'd5);

        // Twenty back-to-back branches: counter saturates at 15.
        for (int k = 0; k < 20; k++)
            vec(0, 0, 1, 1, 32'h4, 0, 32'h0, 0, 32'h0, 1, 32'h4, 0, 1,
                (k == 0) ? 2'd1 : 2'd3, (5 + k > 15) ? 4'd15 : 4'(5 + k));
        adv(0, 1, 2'd3, 4'd15);

        // Reset asserted mid-DRAIN.
        vec(1, 0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 0, 1, 2'd3, 4'd15);
        vec(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 0, 1, 2'd0, 4'd0);
        adv(0, 1, 2'd3, 4'd0);
        adv(0, 1, 2'd3, 4'd0);
        adv(1, 0, 2'd1, 4'd0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_err = n_err + 1;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Next-PC sequencer for the fetch stage. It drives the 32-bit PC register's control inputs: write enable, write data, branch select and branch value.
- It arbitrates between three sources of PC update: an absolute PC write (R15 writeback or exception vector), a relative branch from EX, and stall requests from the hazard unit or instruction memory.
- After every redirect it generates pipeline flush bubbles and keeps a saturating redirect count for debug.

Parameters:
- RESET_VEC, 32'h0000_0000, address loaded into the PC while in BOOT.
- FLUSH_DEPTH, 2, number of advancing fetch slots killed after a redirect; legal range 1..15.
- CW, 16, width of redir_count.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset: synchronous, active-high.
- pc_cur  in  32  current fetch address from the PC register.
- stall  in  1  hazard unit requests a hold of fetch.
- imem_ready  in  1  instruction memory accepts a fetch this cycle.
- br_valid  in  1  relative branch taken in EX.
- br_off  in  32  signed byte offset for the branch.
- pcw_valid  in  1  absolute PC write request.
- pcw_data  in  32  absolute target address.
- pc_we  out  1  PC register write enable.
- pc_wd  out  32  PC register write data.
- pc_ib  out  1  PC register branch select.
- pc_bv  out  32  PC register branch value.
- fetch_valid  out  1  current fetch slot holds a real instruction.
- flush  out  1  kill the instructions in IF/ID this cycle.
- state_o  out  2  current state: BOOT=0, RUN=1, HOLD=2, DRAIN=3.
- redir_count  out  CW  saturating count of redirects.

Behaviour:
- Registered state: state, drain counter dcnt (4 bits), redir_count. All other outputs are combinational from state and inputs, so a redirect takes effect in the same cycle it is requested.
- Default outputs: pc_we=0, pc_wd=0, pc_ib=0, pc_bv=0, fetch_valid=0, flush=0. With both pc_we and pc_ib low, the PC advances by 4.
- Reset:
  - Any posedge with rst=1 sets state=BOOT, dcnt=0, redir_count=0. This applies in every state, including mid-DRAIN and mid-HOLD.
  - The reset values above hold as outputs while rst=1.
- BOOT:
  - Outputs: pc_we=1, pc_wd=RESET_VEC, flush=1.
  - On the first posedge with rst=0: go to DRAIN, dcnt=FLUSH_DEPTH. A boot is not counted as a redirect.
- Redirect priority, applied in RUN, HOLD and DRAIN: pcw_valid > br_valid > (stall | !imem_ready) > advance.
  - pcw_valid: pc_we=1, pc_wd=pcw_data, pc_ib=0, flush=1. Next state DRAIN, dcnt=FLUSH_DEPTH, redir_count+1.
  - br_valid (pcw_valid=0): pc_ib=1, pc_bv=br_off, pc_we=0, flush=1. Next state DRAIN, dcnt=FLUSH_DEPTH, redir_count+1.
  - A redirect inside DRAIN reloads dcnt to FLUSH_DEPTH; the drain window restarts.
- RUN:
  - stall | !imem_ready: pc_we=1, pc_wd=pc_cur (hold), fetch_valid=0; next state HOLD.
  - Otherwise: fetch_valid=1, PC advances.
- HOLD:
  - PC held as in RUN-stall, fetch_valid=0.
  - When stall=0 and imem_ready=1: advance this cycle with fetch_valid=1; next state RUN.
- DRAIN:
  - flush=1 and fetch_valid=0 throughout.
  - If stall | !imem_ready: PC held and dcnt frozen.
  - Otherwise: PC advances and dcnt decrements.
  - When dcnt=1 and decrementing: next state RUN.
  - Exactly FLUSH_DEPTH advancing slots are killed per redirect.
- redir_count:
  - Saturates at 2^CW-1; no wrap-around.
  - Increments at most once per cycle.
- Arithmetic: all addresses are 32-bit unsigned with modulo-2^32 wrap. This block performs no addition; the offset is passed through unmodified.

Test Plan:
- Boot: rst=1 for 3 cycles (RESET_VEC=0) -> pc_we=1, pc_wd=0, state_o=0. Release -> state_o=3 with flush=1, fetch_valid=0 for 2 cycles, then state_o=1, fetch_valid=1, pc_we=0, redir_count=0.
- Branch in RUN: br_valid=1, br_off=32'hFFFF_FFF8 for 1 cycle -> same cycle pc_ib=1, pc_bv=32'hFFFF_FFF8, flush=1. Next 2 cycles flush=1, then fetch_valid=1; redir_count=1.
- Simultaneous requests: pcw_valid=1, pcw_data=32'h100, br_valid=1, stall=1 -> pc_we=1, pc_wd=32'h100, pc_ib=0; redir_count increments by exactly 1.
- Stall: in RUN with pc_cur=32'h40, stall=1 for 3 cycles -> pc_we=1, pc_wd=32'h40, fetch_valid=0, state_o=2. On release -> fetch_valid=1 the same cycle, RUN on the next cycle.
- Stall and re-redirect in DRAIN: branch, then stall=1 for 4 cycles during DRAIN -> dcnt frozen and flush stays 1, RUN only after 2 advancing cycles. A second branch mid-DRAIN -> drain restarts with 2 full slots.
- Saturation and reset: CW=4, 20 consecutive branches -> redir_count=15. Assert rst mid-DRAIN -> next cycle state_o=0, redir_count=0, pc_wd=RESET_VEC.
